// File: rtl/sine_wave_analyzer.sv
// Period/peak/trough analyzer for an unsigned sine stream with a valid/ready result slot.
// Optional peak_index result field enabled by defining SINE_ANALYZER_PEAK_INDEX_EN.
module sine_wave_analyzer #(
  parameter int unsigned SINE_SIZE = 8,
  parameter int unsigned MIDPOINT  = 128,
  parameter int unsigned HYST      = 4,
  parameter int unsigned PERIOD_W  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 sample_valid,
  input  logic [SINE_SIZE-1:0] sample,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [PERIOD_W-1:0]  period,
  output logic [SINE_SIZE-1:0] peak,
  output logic [SINE_SIZE-1:0] trough,
  output logic                 locked,
  output logic                 overrun,
  output logic                 lost
`ifdef SINE_ANALYZER_PEAK_INDEX_EN
  ,
  output logic [PERIOD_W-1:0]  peak_index
`endif
);

  localparam logic [SINE_SIZE:0] HI = (SINE_SIZE+1)'(MIDPOINT + HYST);
  localparam logic [SINE_SIZE:0] LO = (SINE_SIZE+1)'(MIDPOINT - HYST);

  // The *_FIRST states carry the "no crossing since ARM" flag alongside LOW/HIGH.
  typedef enum logic [2:0] {
    ARM, LOW_FIRST, HIGH_FIRST, LOW, HIGH
  } state_t;

  state_t state, state_nx;

  logic [SINE_SIZE:0]   sample_x;
  logic                 above, below;
  logic                 rise, emit, counting, timeout;
  logic [PERIOD_W-1:0]  count, count_inc;
  logic [SINE_SIZE-1:0] run_max, run_min;
`ifdef SINE_ANALYZER_PEAK_INDEX_EN
  logic [PERIOD_W-1:0]  run_idx;
`endif

  assign sample_x  = {1'b0, sample};
  assign above     = sample_x > HI;
  assign below     = sample_x < LO;
  assign count_inc = count + PERIOD_W'(1);

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ARM;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = ARM;
    end else if (sample_valid) begin
      unique case (state)
        ARM:        if (below) state_nx = LOW_FIRST;
        LOW_FIRST:  if (above) state_nx = HIGH_FIRST;
        HIGH_FIRST: if (below) state_nx = LOW;
        LOW:        if (above) state_nx = HIGH;
        HIGH:       if (below) state_nx = LOW;
        default:    state_nx = ARM;
      endcase
    end
  end

  always_comb begin
    rise     = 1'b0;
    emit     = 1'b0;
    counting = 1'b0;
    timeout  = 1'b0;
    if (sample_valid) begin
      rise     = above && (state == LOW_FIRST || state == LOW);
      emit     = above && (state == LOW);
      counting = !rise && (state == HIGH_FIRST || state == LOW || state == HIGH);
    end
    // Stop one short of all-ones so the period counter can never wrap.
    timeout = counting && (count_inc == '1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n || timeout) begin
      count   <= '0;
      run_max <= '0;
      run_min <= '1;
`ifdef SINE_ANALYZER_PEAK_INDEX_EN
      run_idx <= '0;
`endif
    end else if (rise) begin
      count   <= PERIOD_W'(1);
      run_max <= sample;
      run_min <= sample;
`ifdef SINE_ANALYZER_PEAK_INDEX_EN
      run_idx <= PERIOD_W'(1);
`endif
    end else if (counting) begin
      count <= count_inc;
      if (sample > run_max) begin
        run_max <= sample;
`ifdef SINE_ANALYZER_PEAK_INDEX_EN
        run_idx <= count_inc;
`endif
      end
      if (sample < run_min) run_min <= sample;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      result_valid <= 1'b0;
      period       <= '0;
      peak         <= '0;
      trough       <= '0;
      locked       <= 1'b0;
      overrun      <= 1'b0;
      lost         <= 1'b0;
`ifdef SINE_ANALYZER_PEAK_INDEX_EN
      peak_index   <= '0;
`endif
    end else begin
      lost <= timeout;
      if (timeout) locked <= 1'b0;
      if (emit) begin
        locked <= 1'b1;
        if (result_valid && !result_ready) begin
          overrun <= 1'b1;
        end else begin
          result_valid <= 1'b1;
          period       <= count;
          peak         <= run_max;
          trough       <= run_min;
`ifdef SINE_ANALYZER_PEAK_INDEX_EN
          peak_index   <= run_idx;
`endif
        end
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sine_wave_analyzer.sv
// Directed bench for sine_wave_analyzer: triangle streams, gaps, backpressure, timeout, reset.
// Checks peak_index too when SINE_ANALYZER_PEAK_INDEX_EN is defined.
module tb_sine_wave_analyzer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [7:0]  sample;
  logic        result_valid;
  logic        result_ready;
  logic [15:0] period;
  logic [7:0]  peak;
  logic [7:0]  trough;
  logic        locked;
  logic        overrun;
  logic        lost;
`ifdef SINE_ANALYZER_PEAK_INDEX_EN
  logic [15:0] peak_index;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned rv_start = 0;
  int unsigned rv_start_prev = 0;
  logic        rv_prev = 1'b0;

  always #5 clock = ~clock;

  sine_wave_analyzer #(
    .SINE_SIZE(8),
    .MIDPOINT (128),
    .HYST     (4),
    .PERIOD_W (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sample_valid(sample_valid),
    .sample      (sample),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .period      (period),
    .peak        (peak),
    .trough      (trough),
    .locked      (locked),
    .overrun     (overrun),
    .lost        (lost)
`ifdef SINE_ANALYZER_PEAK_INDEX_EN
    ,
    .peak_index  (peak_index)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change just after negedge; outputs are read at the following negedge.
  task automatic apply(input logic v, input logic [7:0] s);
    sample_valid = v;
    sample       = s;
    @(negedge clock);
    cyc++;
    if (result_valid === 1'b1 && rv_prev !== 1'b1) begin
      rv_start_prev = rv_start;
      rv_start      = cyc;
    end
    rv_prev = result_valid;
  endtask

  task automatic feed(input int v, input bit gap);
    apply(1'b1, 8'(v));
    if (gap) apply(1'b0, 8'hFF);
  endtask

  task automatic up_to_128(input bit gap);
    for (int v = 0; v <= 128; v += 8) feed(v, gap);
  endtask

  task automatic rest(input int hi, input bit gap);
    for (int v = 144; v <= hi; v += 8) feed(v, gap);
    for (int v = hi - 8; v >= 8; v -= 8) feed(v, gap);
  endtask

  task automatic check_res(input string tag, input logic rv, input int unsigned per,
                           input int unsigned pk, input int unsigned tr, input int unsigned idx);
    chk({tag, ".valid"},  result_valid, rv);
    chk({tag, ".period"}, period, per);
    chk({tag, ".peak"},   peak, pk);
    chk({tag, ".trough"}, trough, tr);
`ifdef SINE_ANALYZER_PEAK_INDEX_EN
    chk({tag, ".peak_index"}, peak_index, idx);
`else
    if (idx > 65535) chk({tag, ".idx_range"}, idx, 0);
`endif
  endtask

  initial begin
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample       = 8'd0;
    result_ready = 1'b0;
    apply(1'b0, 8'd0);
    apply(1'b1, 8'd0);
    check_res("reset", 1'b0, 0, 0, 0, 0);
    chk("reset.locked",  locked, 0);
    chk("reset.overrun", overrun, 0);
    chk("reset.lost",    lost, 0);

    // Continuous triangle 0..248..8, ready high
    reset_n      = 1'b1;
    result_ready = 1'b1;
    up_to_128(0);
    apply(1'b1, 8'd136);
    chk("t1.first_cross.valid",  result_valid, 0);
    chk("t1.first_cross.locked", locked, 0);
    rest(248, 0);
    up_to_128(0);
    apply(1'b1, 8'd136);
    check_res("t1.emit1", 1'b1, 62, 248, 0, 15);
    chk("t1.emit1.locked", locked, 1);
    rest(248, 0);
    chk("t1.drop.valid", result_valid, 0);
    up_to_128(0);
    apply(1'b1, 8'd136);
    check_res("t1.emit2", 1'b1, 62, 248, 0, 15);
    rest(248, 0);

    // Same stream with an idle cycle after every sample
    up_to_128(1);
    apply(1'b1, 8'd136);
    check_res("t2.emit1", 1'b1, 62, 248, 0, 15);
    apply(1'b0, 8'hFF);
    rest(248, 1);
    up_to_128(1);
    apply(1'b1, 8'd136);
    check_res("t2.emit2", 1'b1, 62, 248, 0, 15);
    chk("t2.spacing", rv_start - rv_start_prev, 124);
    apply(1'b0, 8'hFF);

    // Backpressure across two emits; second period has a lower peak
    result_ready = 1'b0;
    rest(200, 0);
    up_to_128(0);
    apply(1'b1, 8'd136);
    check_res("t3.emit", 1'b1, 50, 200, 0, 9);
    chk("t3.emit.overrun", overrun, 0);
    rest(248, 0);
    check_res("t3.hold", 1'b1, 50, 200, 0, 9);
    up_to_128(0);
    apply(1'b1, 8'd136);
    check_res("t3.dropped", 1'b1, 50, 200, 0, 9);
    chk("t3.overrun", overrun, 1);
    result_ready = 1'b1;
    apply(1'b0, 8'd0);
    chk("t3.consume.valid",   result_valid, 0);
    chk("t3.consume.overrun", overrun, 1);

    // Lock, then hold the input at midpoint until the counter times out
    rest(248, 0);
    up_to_128(0);
    apply(1'b1, 8'd136);
    check_res("t4.emit", 1'b1, 62, 248, 0, 15);
    chk("t4.emit.locked", locked, 1);
    for (int i = 0; i < 65533; i++) apply(1'b1, 8'd128);
    chk("t4.pre.lost",   lost, 0);
    chk("t4.pre.locked", locked, 1);
    chk("t4.pre.valid",  result_valid, 0);
    apply(1'b1, 8'd128);
    chk("t4.lost",         lost, 1);
    chk("t4.lost.locked",  locked, 0);
    chk("t4.lost.overrun", overrun, 1);
    apply(1'b1, 8'd128);
    chk("t4.lost_pulse", lost, 0);
    apply(1'b1, 8'd200);
    apply(1'b1, 8'd0);
    apply(1'b1, 8'd136);
    chk("t4.rearm.valid",  result_valid, 0);
    chk("t4.rearm.locked", locked, 0);

    // Pending result, then reset mid-period
    rest(248, 0);
    up_to_128(0);
    result_ready = 1'b0;
    apply(1'b1, 8'd136);
    check_res("t5.pending", 1'b1, 62, 248, 0, 15);
    apply(1'b1, 8'd144);
    reset_n = 1'b0;
    apply(1'b1, 8'd160);
    check_res("t5.reset", 1'b0, 0, 0, 0, 0);
    chk("t5.reset.locked",  locked, 0);
    chk("t5.reset.overrun", overrun, 0);
    chk("t5.reset.lost",    lost, 0);

    // Chatter between and on the thresholds produces no crossings
    reset_n      = 1'b1;
    result_ready = 1'b1;
    apply(1'b1, 8'd0);
    apply(1'b1, 8'd136);
    apply(1'b1, 8'd0);
    for (int r = 0; r < 4; r++)
      for (int v = 124; v <= 132; v += 2) apply(1'b1, 8'(v));
    chk("t5.chatter_low.valid",  result_valid, 0);
    chk("t5.chatter_low.locked", locked, 0);
    apply(1'b1, 8'd136);
    check_res("t5.short", 1'b1, 22, 136, 0, 1);
    for (int r = 0; r < 4; r++)
      for (int v = 124; v <= 132; v += 2) apply(1'b1, 8'(v));
    chk("t5.chatter_high.valid", result_valid, 0);
    apply(1'b1, 8'd136);
    chk("t5.no_cross.valid", result_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
